grostl_ctrl_serial: RTL and testbench

Sequencing controller for the serial Grøstl compression datapath (`grostl_compress_serial`). It accepts one 512-bit message block per handshake and drives the datapath's write enables, mux selects, P/Q select and round number. Each block is evaluated as f(h,m) = P(h⊕m) ⊕ Q(m) ⊕ h, using a two-cycle-per-round schedule. The controller sits between the block-feeding logic and the compression datapath, inside the serial Grøstl top level.

---
 rtl/grostl_ctrl_pkg.sv | 29 ++
 rtl/grostl_ctrl_serial_if.sv | 23 ++
 rtl/grostl_ctrl_serial.sv | 154 +++++++++++++++
 tb/tb_grostl_ctrl_serial.sv | 128 ++++++++++++
 4 files changed

// File: rtl/grostl_ctrl_pkg.sv
// Shared types and encodings for the serial Grostl compression sequencer.
package grostl_ctrl_pkg;

   localparam int NUM_ROUNDS = 10;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LOAD,
      ST_XOR,
      ST_P_S1,
      ST_P_S2,
      ST_HUPD,
      ST_RELOAD,
      ST_Q_S1,
      ST_Q_S2,
      ST_FINAL
   } state_t;

   localparam logic [1:0] SEL_M_MSG = 2'b00;
   localparam logic [1:0] SEL_M_MIX = 2'b01;
   localparam logic [1:0] SEL_M_XOR = 2'b10;

   localparam logic SEL_H_IV  = 1'b0;
   localparam logic SEL_H_XOR = 1'b1;

   localparam logic PQ_P = 1'b0;
   localparam logic PQ_Q = 1'b1;

endpackage

// File: rtl/grostl_ctrl_serial_if.sv
// Block handshake plus datapath control bus between feeder, sequencer and compression datapath.
interface grostl_ctrl_serial_if;
   logic       msg_valid;
   logic       msg_first;
   logic       msg_ready;
   logic       done;
   logic       wr_m;
   logic       wr_h;
   logic [1:0] sel_m;
   logic       sel_h;
   logic       sel_pq;
   logic [3:0] round;

   modport master (
      input  msg_valid, msg_first,
      output msg_ready, done, wr_m, wr_h, sel_m, sel_h, sel_pq, round
   );

   modport slave (
      output msg_valid, msg_first,
      input  msg_ready, done, wr_m, wr_h, sel_m, sel_h, sel_pq, round
   );
endinterface

// File: rtl/grostl_ctrl_serial.sv
// Sequencer for the serial Grostl datapath: f(h,m) = P(h^m) ^ Q(m) ^ h, two cycles per round.
//
// state     | meaning
// ----------|----------------------------------------------------------
// IDLE      | waiting for a block; msg_ready high, done pulses here
// LOAD      | m_reg <= m_in; h_reg <= IV when the block is first
// XOR       | m_reg <= h ^ m
// P_S1      | P round, first pipeline stage
// P_S2      | P round, second stage; m_reg <= round output
// HUPD      | h_reg <= P(h^m) ^ h
// RELOAD    | m_reg <= m_in again for the Q permutation
// Q_S1      | Q round, first pipeline stage
// Q_S2      | Q round, second stage; m_reg <= round output
// FINAL     | both registers <= Q(m) ^ P(h^m) ^ h
module grostl_ctrl_serial
   import grostl_ctrl_pkg::*;
#(
   parameter int NUM_ROUNDS = grostl_ctrl_pkg::NUM_ROUNDS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   grostl_ctrl_serial_if.master bus
);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic       first_q, first_d;
   logic       done_q, done_d;
   logic       last_rnd;

   assign last_rnd = (cnt_q == 4'(NUM_ROUNDS - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         first_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= first_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      first_d = first_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.msg_valid) begin
               state_d = ST_LOAD;
               first_d = bus.msg_first;
            end
         end
         ST_LOAD:   state_d = ST_XOR;
         ST_XOR:    state_d = ST_P_S1;
         ST_P_S1:   state_d = ST_P_S2;
         ST_P_S2: begin
            if (last_rnd) begin
               state_d = ST_HUPD;
               cnt_d   = 4'd0;
            end else begin
               state_d = ST_P_S1;
               cnt_d   = cnt_q + 4'd1;
            end
         end
         ST_HUPD:   state_d = ST_RELOAD;
         ST_RELOAD: state_d = ST_Q_S1;
         ST_Q_S1:   state_d = ST_Q_S2;
         ST_Q_S2: begin
            if (last_rnd) begin
               state_d = ST_FINAL;
               cnt_d   = 4'd0;
            end else begin
               state_d = ST_Q_S1;
               cnt_d   = cnt_q + 4'd1;
            end
         end
         ST_FINAL: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = 4'd0;
         end
      endcase
   end

   // sel_pq and round stay constant over S1/S2: the second datapath stage uses them a cycle late
   always_comb begin
      bus.msg_ready = 1'b0;
      bus.done      = done_q;
      bus.wr_m      = 1'b0;
      bus.wr_h      = 1'b0;
      bus.sel_m     = SEL_M_MSG;
      bus.sel_h     = SEL_H_IV;
      bus.sel_pq    = PQ_P;
      bus.round     = 4'd0;
      case (state_q)
         ST_IDLE: bus.msg_ready = 1'b1;
         ST_LOAD: begin
            bus.wr_m  = 1'b1;
            bus.sel_m = SEL_M_MSG;
            bus.wr_h  = first_q;
            bus.sel_h = SEL_H_IV;
         end
         ST_XOR: begin
            bus.wr_m  = 1'b1;
            bus.sel_m = SEL_M_XOR;
         end
         ST_P_S1: begin
            bus.sel_pq = PQ_P;
            bus.round  = cnt_q;
         end
         ST_P_S2: begin
            bus.sel_pq = PQ_P;
            bus.round  = cnt_q;
            bus.wr_m   = 1'b1;
            bus.sel_m  = SEL_M_MIX;
         end
         ST_HUPD: begin
            bus.wr_h  = 1'b1;
            bus.sel_h = SEL_H_XOR;
         end
         ST_RELOAD: begin
            bus.wr_m  = 1'b1;
            bus.sel_m = SEL_M_MSG;
         end
         ST_Q_S1: begin
            bus.sel_pq = PQ_Q;
            bus.round  = cnt_q;
         end
         ST_Q_S2: begin
            bus.sel_pq = PQ_Q;
            bus.round  = cnt_q;
            bus.wr_m   = 1'b1;
            bus.sel_m  = SEL_M_MIX;
         end
         ST_FINAL: begin
            bus.wr_m  = 1'b1;
            bus.sel_m = SEL_M_XOR;
            bus.wr_h  = 1'b1;
            bus.sel_h = SEL_H_XOR;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_grostl_ctrl_serial.sv
// Directed bench for the Grostl sequencer: per-cycle control map, chaining, busy ignore, mid-block reset.
module tb_grostl_ctrl_serial;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   grostl_ctrl_serial_if bus ();

   grostl_ctrl_serial #(.NUM_ROUNDS(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [11:0] ctl_vec();
      return {bus.msg_ready, bus.done, bus.wr_m, bus.wr_h, bus.sel_m,
              bus.sel_h, bus.sel_pq, bus.round};
   endfunction

   // Hand-built cycle map; c counts clocks after the handshake edge
   function automatic logic [11:0] exp_vec(input int c, input logic first);
      logic       rdy = 1'b0;
      logic       dn  = 1'b0;
      logic       wm  = 1'b0;
      logic       wh  = 1'b0;
      logic [1:0] sm  = 2'b00;
      logic       sh  = 1'b0;
      logic       pq  = 1'b0;
      logic [3:0] rd  = 4'd0;
      if (c == 1) begin
         wm = 1'b1; sm = 2'b00; wh = first;
      end else if (c == 2) begin
         wm = 1'b1; sm = 2'b10;
      end else if (c >= 3 && c <= 22) begin
         rd = 4'((c - 3) / 2);
         if ((c - 3) % 2 == 1) begin wm = 1'b1; sm = 2'b01; end
      end else if (c == 23) begin
         wh = 1'b1; sh = 1'b1;
      end else if (c == 24) begin
         wm = 1'b1; sm = 2'b00;
      end else if (c >= 25 && c <= 44) begin
         pq = 1'b1;
         rd = 4'((c - 25) / 2);
         if ((c - 25) % 2 == 1) begin wm = 1'b1; sm = 2'b01; end
      end else if (c == 45) begin
         wm = 1'b1; sm = 2'b10; wh = 1'b1; sh = 1'b1;
      end else begin
         rdy = 1'b1; dn = (c == 46);
      end
      return {rdy, dn, wm, wh, sm, sh, pq, rd};
   endfunction

   // Entered at a negedge while idle; returns at the negedge of cycle 46
   task automatic run_block(input string name, input logic first, input logic hold);
      bus.msg_valid = 1'b1;
      bus.msg_first = first;
      @(posedge clk);
      for (int c = 1; c <= 46; c++) begin
         @(negedge clk);
         if (c == 1 && !hold) bus.msg_valid = 1'b0;
         check_eq($sformatf("%s_c%0d", name, c), 32'(ctl_vec()), 32'(exp_vec(c, first)));
      end
   endtask

   initial begin
      n_checks      = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.msg_valid = 1'b0;
      bus.msg_first = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("reset_outputs", 32'(ctl_vec()), 32'h800);
      rst_n = 1'b1;
      @(negedge clk);
      check_eq("idle_after_reset", 32'(ctl_vec()), 32'h800);

      run_block("single", 1'b1, 1'b0);

      // back-to-back: second handshake lands in the done cycle of the first
      @(negedge clk);
      run_block("chain_a", 1'b1, 1'b0);
      run_block("chain_b", 1'b0, 1'b0);
      check_eq("chain_done_c92", 32'(bus.done), 32'd1);

      // msg_valid stays high: no new handshake until the done cycle
      @(negedge clk);
      run_block("busy", 1'b1, 1'b1);

      // the held valid is taken at edge 46; reset lands mid cycle 10 of that block
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) bus.msg_valid = 1'b0;
         check_eq($sformatf("pre_rst_c%0d", c), 32'(ctl_vec()), 32'(exp_vec(c, 1'b1)));
      end
      rst_n = 1'b0;
      #1;
      check_eq("rst_ready", 32'(bus.msg_ready), 32'd1);
      check_eq("rst_wr_m", 32'(bus.wr_m), 32'd0);
      check_eq("rst_wr_h", 32'(bus.wr_h), 32'd0);
      check_eq("rst_vec", 32'(ctl_vec()), 32'h800);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         check_eq($sformatf("no_done_%0d", c), 32'(bus.done), 32'd0);
      end

      run_block("recover", 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
